// File: rtl/softmax_vec_packer_pkg.sv
// Shared constants and helpers for the softmax reduction datapath.
package softmax_vec_packer_pkg;

    localparam int          FP16_W    = 16;
    localparam logic [15:0] FP16_ZERO = 16'h0000;

    // An element count runs 0..n inclusive, so it needs one bit more than log2(n).
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/softmax_vec_bank.sv
// One ping-pong bank: N FP16 lane registers written W lanes per beat, a full flag,
// the real-element count and a pad-masked read of the stored vector.
module softmax_vec_bank
    import softmax_vec_packer_pkg::*;
#(
    parameter  int N     = 64,
    parameter  int W     = 4,
    localparam int BEATS = N / W,
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int CW    = cnt_width(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [BW-1:0]         wr_beat,
    input  logic [W*FP16_W-1:0]   wr_data,
    input  logic                  set_full,
    input  logic [CW-1:0]         set_count,
    input  logic                  clr_full,
    output logic                  full,
    output logic [CW-1:0]         count,
    output logic [N*FP16_W-1:0]   rd_flat
);

    logic [N*FP16_W-1:0] data_q, data_d;
    logic                full_q, full_d;
    logic [CW-1:0]       count_q, count_d;

    always_comb begin
        data_d  = data_q;
        full_d  = full_q;
        count_d = count_q;
        if (wr_en) begin
            data_d[int'(wr_beat)*W*FP16_W +: W*FP16_W] = wr_data;
        end
        if (clr_full) begin
            full_d = 1'b0;
        end
        if (set_full) begin
            full_d  = 1'b1;
            count_d = set_count;
        end
    end

    // Lane data carries no reset: it is never observed unless the full flag is set.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q  <= 1'b0;
            count_q <= '0;
        end else begin
            full_q  <= full_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        rd_flat = '0;
        for (int i = 0; i < N; i++) begin
            if (full_q && (i < int'(count_q))) begin
                rd_flat[i*FP16_W +: FP16_W] = data_q[i*FP16_W +: FP16_W];
            end else begin
                rd_flat[i*FP16_W +: FP16_W] = FP16_ZERO;
            end
        end
    end

    assign full  = full_q;
    assign count = count_q;

endmodule

// File: rtl/softmax_vec_packer.sv
// Serial-to-parallel FP16 packer: W lanes per beat into N-element vectors through
// two ping-pong banks, with short vectors terminated by in_last and zero-padded.
module softmax_vec_packer
    import softmax_vec_packer_pkg::*;
#(
    parameter int N = 64,
    parameter int W = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [W*FP16_W-1:0]         in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [N*FP16_W-1:0]         out_flat,
    output logic [cnt_width(N)-1:0]     out_count
);

    localparam int BEATS = N / W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW    = cnt_width(N);

    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic [BW-1:0] beat_q, beat_d;

    logic                  full  [2];
    logic [CW-1:0]         count [2];
    logic [N*FP16_W-1:0]   flat  [2];

    logic          accept;
    logic          complete;
    logic          rel;
    logic [CW-1:0] done_count;

    // in_ready depends only on registered flags, never on out_ready.
    assign in_ready   = !full[wr_sel_q];
    assign accept     = in_valid && in_ready;
    assign complete   = accept && ((int'(beat_q) == BEATS - 1) || in_last);
    assign done_count = CW'((int'(beat_q) + 1) * W);

    assign out_valid  = full[rd_sel_q];
    assign rel        = out_valid && out_ready;
    assign out_count  = out_valid ? count[rd_sel_q] : '0;
    assign out_flat   = flat[rd_sel_q];

    for (genvar g = 0; g < 2; g++) begin : g_bank
        softmax_vec_bank #(
            .N (N),
            .W (W)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (accept && (wr_sel_q == 1'(g))),
            .wr_beat   (beat_q),
            .wr_data   (in_data),
            .set_full  (complete && (wr_sel_q == 1'(g))),
            .set_count (done_count),
            .clr_full  (rel && (rd_sel_q == 1'(g))),
            .full      (full[g]),
            .count     (count[g]),
            .rd_flat   (flat[g])
        );
    end

    always_comb begin
        beat_d   = beat_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        if (accept) begin
            if (complete) begin
                beat_d   = '0;
                wr_sel_d = ~wr_sel_q;
            end else begin
                beat_d   = beat_q + 1'b1;
            end
        end
        if (rel) begin
            rd_sel_d = ~rd_sel_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            beat_q   <= '0;
        end else begin
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            beat_q   <= beat_d;
        end
    end

endmodule

// File: tb/tb_softmax_vec_packer.sv
// Scoreboard bench for softmax_vec_packer (N=64, W=4).
module tb_softmax_vec_packer;

    localparam int N     = 64;
    localparam int W     = 4;
    localparam int BEATS = N / W;
    localparam int CW    = $clog2(N) + 1;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [W*16-1:0]   in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [N*16-1:0]   out_flat;
    logic [CW-1:0]     out_count;

    softmax_vec_packer #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_flat  (out_flat),
        .out_count (out_count)
    );

    typedef struct {
        logic [15:0] base;
        int          cnt;
    } exp_t;

    exp_t            sb[$];
    int              hs_cyc_q[$];
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    int              vld_cycles = 0;
    int              stall_cnt = 0;
    int              last_acc_cyc = 0;
    logic            prev_stall = 1'b0;
    logic [N*16-1:0] prev_flat = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Output monitor: stall stability and scoreboard compare at every handshake.
    always @(negedge clk) begin
        if (rst && prev_stall) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_flat_stable", 32'(out_flat == prev_flat), 32'd1);
        end
        if (rst && out_valid) vld_cycles <= vld_cycles + 1;
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_vector", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_count", 32'(out_count), 32'(e.cnt));
                for (int i = 0; i < N; i++) begin
                    check($sformatf("elem%0d", i), 32'(out_flat[i*16 +: 16]),
                          (i < e.cnt) ? 32'(e.base + 16'(i)) : 32'h0);
                end
            end
            hs_cyc_q.push_back(cyc);
        end
        prev_stall <= rst && out_valid && !out_ready;
        prev_flat  <= out_flat;
    end

    task automatic drive_beat(input logic [W*16-1:0] d, input logic last);
        bit rdy;
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        rdy = 1'b0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            if (!rdy) stall_cnt++;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 300);
        if (!rdy) check("accept_timeout", 32'd0, 32'd1);
        else last_acc_cyc = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_vec(input logic [15:0] base, input int nbeats, input logic last,
                            input bit push);
        logic [W*16-1:0] d;
        if (push) sb.push_back(exp_t'{base: base, cnt: nbeats * W});
        for (int b = 0; b < nbeats; b++) begin
            for (int k = 0; k < W; k++) d[k*16 +: 16] = base + 16'(b * W + k);
            drive_beat(d, last && (b == nbeats - 1));
        end
    endtask

    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int n0;
        int s0;
        logic [W*16-1:0] d;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Reset then idle
        repeat (10) begin
            @(negedge clk);
            check("idle_in_ready", 32'(in_ready), 32'd1);
            check("idle_out_valid", 32'(out_valid), 32'd0);
            check("idle_out_count", 32'(out_count), 32'd0);
            check("idle_flat_nonzero", 32'(out_flat != '0), 32'd0);
        end
        @(posedge clk);
        #1;

        // One full vector, consumer always ready
        out_ready = 1'b1;
        v0 = vld_cycles;
        send_vec(16'h3C00, BEATS, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("full_vec_pulses", 32'(vld_cycles - v0), 32'd1);
        check("full_vec_latency", 32'(hs_cyc_q[$]), 32'(last_acc_cyc));
        check("full_vec_drained", 32'(sb.size()), 32'd0);

        // Short vector terminated by in_last
        v0 = vld_cycles;
        send_vec(16'h4000, 3, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("short_vec_pulses", 32'(vld_cycles - v0), 32'd1);
        check("short_vec_latency", 32'(hs_cyc_q[$]), 32'(last_acc_cyc));

        // Consumer stall fills both banks
        out_ready = 1'b0;
        send_vec(16'h5000, BEATS, 1'b0, 1'b1);
        send_vec(16'h5400, BEATS, 1'b0, 1'b1);
        for (int k = 0; k < W; k++) d[k*16 +: 16] = 16'h5800 + 16'(k);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_elem0", 32'(out_flat[15:0]), 32'h5000);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd1);
        check("release_next_elem0", 32'(out_flat[15:0]), 32'h5400);
        @(posedge clk);
        #1;
        send_vec(16'h5800, BEATS, 1'b0, 1'b1);
        out_ready = 1'b1;
        wait_drain(200);

        // Continuous stream, zero bubbles
        n0 = hs_cyc_q.size();
        s0 = stall_cnt;
        for (int v = 0; v < 4; v++) send_vec(16'h6000 + 16'(v * 16'h100), BEATS, 1'b0, 1'b1);
        wait_drain(100);
        check("stream_pulses", 32'(hs_cyc_q.size() - n0), 32'd4);
        if (hs_cyc_q.size() - n0 == 4) begin
            for (int j = 1; j < 4; j++)
                check($sformatf("stream_gap%0d", j),
                      32'(hs_cyc_q[n0 + j] - hs_cyc_q[n0 + j - 1]), 32'd16);
        end
        check("stream_in_ready_drops", 32'(stall_cnt - s0), 32'd0);

        // Reset mid-vector with a pending full vector
        out_ready = 1'b0;
        send_vec(16'h7000, BEATS, 1'b0, 1'b0);
        send_vec(16'h7400, 7, 1'b0, 1'b0);
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("reset_async_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("reset_out_count", 32'(out_count), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_flat_nonzero", 32'(out_flat != '0), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        out_ready = 1'b1;
        n0 = hs_cyc_q.size();
        send_vec(16'h7800, BEATS, 1'b0, 1'b1);
        wait_drain(50);
        check("post_reset_vectors", 32'(hs_cyc_q.size() - n0), 32'd1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
